rr_req_sched: RTL and testbench

RR_REQ_SCHED -- requirements
Module: rr_req_sched

---
 rtl/rr_req_sched.sv | 124 ++++++++++++
 tb/tb_rr_req_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_sched.sv
// Round-robin request scheduler: IDLE/HOLD/GAP grant FSM with hold timeout.
// Optional built-in assertions are compiled in when SVA_CHECK_EN is defined.
module rr_req_sched #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] LIMIT = 8'(MAX_HOLD);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [IW-1:0] pick;

  // Descending loop so the nearest set bit after `last` is the final write.
  function automatic logic [IW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    last
  );
    logic [IW-1:0] sel;
    int            idx;
    sel = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (r[idx]) sel = IW'(idx);
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, gnt_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_id  <= IW'(N_REQ - 1);
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= HOLD;
            gnt    <= ONE << pick;
            gnt_id <= pick;
            busy   <= 1'b1;
            cnt    <= 8'd1;
          end
        end
        HOLD: begin
          if (done[gnt_id]) begin
            state <= GAP;
            gnt   <= '0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == LIMIT) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            cnt     <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SVA_CHECK_EN
  localparam int BOUND = N_REQ * (MAX_HOLD + 2);

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt)
  ) else $error("gnt not onehot0: %b", gnt);

  a_gnt_stable: assert property (
    @(posedge clk) disable iff (rst)
    (busy && $past(busy)) |-> $stable(gnt)
  ) else $error("gnt changed while busy");

  a_timeout_cause: assert property (
    @(posedge clk) disable iff (rst)
    timeout |-> $past(busy && cnt == LIMIT)
  ) else $error("timeout without hold limit");

  a_gnt_req: assert property (
    @(posedge clk) disable iff (rst)
    (|(gnt & ~$past(gnt))) |-> (|(gnt & $past(req)))
  ) else $error("grant without prior request");

  for (genvar i = 0; i < N_REQ; i++) begin : g_live
    a_live: assert property (
      @(posedge clk) disable iff (rst)
      (req[i] && !gnt[i]) |-> ##[1:BOUND] (gnt[i] || !req[i])
    ) else $error("requester %0d starved", i);
  end
`endif

endmodule

// File: tb/tb_rr_req_sched.sv
// Bench for rr_req_sched: vector table, corner sequences, random vs model.
module tb_rr_req_sched;

  localparam int N  = 4;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_owner;
  int m_age;
  int m_cool;
  int m_last;
  int m_to;

  always #5 clk = ~clk;

  rr_req_sched #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .done(done),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .busy(busy),
    .timeout(timeout)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tv[22];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq,
                            input logic [3:0] dn);
    if (r) begin
      m_owner = -1;
      m_age   = 0;
      m_cool  = 0;
      m_last  = N - 1;
      m_to    = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        if (dn[m_owner]) begin
          m_owner = -1;
          m_cool  = 1;
        end else if (m_age == MH) begin
          m_owner = -1;
          m_cool  = 1;
          m_to    = 1;
        end else begin
          m_age++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (rq != 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_owner < 0 && rq[c]) m_owner = c;
        end
        m_last = m_owner;
        m_age  = 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] rq,
                       input logic [3:0] dn);
    logic [3:0] eg;
    rst  = r;
    req  = rq;
    done = dn;
    @(posedge clk);
    model_step(r, rq, dn);
    @(negedge clk);
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    check("model gnt", 32'(gnt), 32'(eg));
    check("model gnt_id", 32'(gnt_id), 32'(m_last));
    check("model busy", 32'(busy), 32'(m_owner >= 0));
    check("model timeout", 32'(timeout), 32'(m_to));
  endtask

  initial begin
    int hi;
    int age;
    int cyc;
    logic [3:0] d;
    int order[$];

    tv[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 4'b0010, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tv[10] = '{1'b0, 4'b0000, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
    tv[11] = '{1'b0, 4'b0000, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b0};
    tv[12] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
    tv[13] = '{1'b0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0};
    tv[14] = '{1'b0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tv[15] = '{1'b0, 4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tv[16] = '{1'b0, 4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tv[17] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tv[18] = '{1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tv[19] = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
    tv[20] = '{1'b1, 4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tv[21] = '{1'b0, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};

    for (int i = 0; i < 22; i++) begin
      cycle(tv[i].rst, tv[i].req, tv[i].done);
      check($sformatf("vec%0d gnt", i), 32'(gnt), 32'(tv[i].gnt));
      check($sformatf("vec%0d gnt_id", i), 32'(gnt_id), 32'(tv[i].id));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("vec%0d timeout", i), 32'(timeout), 32'(tv[i].to));
    end

    // round-robin: all request, each grantee finishes after two cycles
    cycle(1'b1, 4'b0000, 4'b0000);
    age = 0;
    d   = 4'b0000;
    cyc = 0;
    while (order.size() < 5 && cyc < 80) begin
      logic pb;
      pb = busy;
      cycle(1'b0, 4'b1111, d);
      cyc++;
      check("rr onehot0", 32'($onehot0(gnt)), 32'd1);
      if (busy && !pb) begin
        order.push_back(int'(gnt_id));
        age = 1;
      end else if (busy) begin
        age++;
      end
      d = (busy && age >= 2) ? gnt : 4'b0000;
    end
    check("rr grant count", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size(); k++)
      check($sformatf("rr order%0d", k), 32'(order[k]), 32'(k % N));

    // timeout: grant held MAX_HOLD cycles, then one timeout pulse
    cycle(1'b1, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0010, 4'b0000);
    hi = (gnt == 4'b0010) ? 1 : 0;
    repeat (MH - 1) begin
      cycle(1'b0, 4'b0010, 4'b0000);
      if (gnt == 4'b0010) hi++;
    end
    check("to hold cycles", 32'(hi), 32'(MH));
    cycle(1'b0, 4'b0010, 4'b0000);
    check("to pulse", 32'(timeout), 32'd1);
    check("to gnt clear", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b0010, 4'b0000);
    check("to one cycle", 32'(timeout), 32'd0);

    // collision: done on the limit cycle wins over timeout
    cycle(1'b1, 4'b0000, 4'b0000);
    cycle(1'b0, 4'b0010, 4'b0000);
    repeat (MH - 1) cycle(1'b0, 4'b0010, 4'b0000);
    cycle(1'b0, 4'b0010, 4'b0010);
    check("col timeout", 32'(timeout), 32'd0);
    check("col gnt", 32'(gnt), 32'd0);
    cycle(1'b0, 4'b0000, 4'b0000);
    check("col timeout late", 32'(timeout), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic       r;
      logic [3:0] rq;
      logic [3:0] dn;
      r  = ($urandom_range(0, 199) == 0);
      rq = 4'($urandom);
      dn = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      cycle(r, rq, dn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
